// File: rtl/c3dfx_tcm_capture_seq.sv
// At-speed capture pulse sequencer feeding the test clock macro's functional clock enable.
// Scan mode: burst of launch/capture enables after scan-enable falls. Functional mode: registered pass-through.
module c3dfx_tcm_capture_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned GAP_W       = 3,
  parameter int unsigned WAIT_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_scan_mode,
  input  logic              i_scan_enable,
  input  logic              i_func_clken,
  input  logic [CNT_W-1:0]  i_num_pulse,
  input  logic [GAP_W-1:0]  i_pulse_gap,
  input  logic [WAIT_W-1:0] i_wait_cyc,
  output logic              o_clken,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_abort
);

  localparam int unsigned TMR_W = (WAIT_W > GAP_W) ? WAIT_W : GAP_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [SYNC_STAGES-1:0] se_sync;
  logic                   se_s;
  logic                   se_d;
  logic                   se_fall;
  logic                   se_rise;

  logic [2:0]       state,     state_n;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_n;
  logic [TMR_W-1:0] tmr,       tmr_n;
  logic [CNT_W-1:0] num_q,     num_n;
  logic [GAP_W-1:0] gap_q,     gap_n;
  logic             clken_n;
  logic             abort_n;

  // Scan-enable synchroniser; resets to shift state so no spurious fall after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      se_sync <= '1;
      se_d    <= 1'b1;
    end else begin
      se_sync <= {se_sync[SYNC_STAGES-2:0], i_scan_enable};
      se_d    <= se_sync[SYNC_STAGES-1];
    end
  end

  assign se_s    = se_sync[SYNC_STAGES-1];
  assign se_fall = se_d & ~se_s;
  assign se_rise = ~se_d & se_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      pulse_cnt <= '0;
      tmr       <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      o_clken   <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      state     <= state_n;
      pulse_cnt <= pulse_cnt_n;
      tmr       <= tmr_n;
      num_q     <= num_n;
      gap_q     <= gap_n;
      o_clken   <= clken_n;
      o_abort   <= abort_n;
    end
  end

  always_comb begin
    state_n     = state;
    pulse_cnt_n = pulse_cnt;
    tmr_n       = tmr;
    num_n       = num_q;
    gap_n       = gap_q;
    clken_n     = 1'b0;
    abort_n     = 1'b0;

    if (!i_scan_mode) begin
      state_n     = S_IDLE;
      pulse_cnt_n = '0;
      tmr_n       = '0;
      clken_n     = i_func_clken;
    end else begin
      case (state)
        S_IDLE: begin
          if (se_fall) begin
            num_n       = (i_num_pulse == '0) ? CNT_W'(1) : i_num_pulse;
            gap_n       = i_pulse_gap;
            pulse_cnt_n = '0;
            if (i_wait_cyc != '0) begin
              state_n = S_WAIT;
              tmr_n   = TMR_W'(i_wait_cyc);
            end else begin
              state_n = S_PULSE;
            end
          end
        end
        S_WAIT, S_GAP: begin
          if (se_rise) begin
            state_n     = S_IDLE;
            abort_n     = 1'b1;
            pulse_cnt_n = '0;
            tmr_n       = '0;
          end else if (tmr == TMR_W'(1)) begin
            state_n = S_PULSE;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr - TMR_W'(1);
          end
        end
        S_PULSE: begin
          if (se_rise) begin
            state_n     = S_IDLE;
            abort_n     = 1'b1;
            pulse_cnt_n = '0;
            tmr_n       = '0;
          end else begin
            pulse_cnt_n = pulse_cnt + CNT_W'(1);
            if (pulse_cnt_n == num_q) begin
              state_n = S_DONE;
            end else if (gap_q != '0) begin
              state_n = S_GAP;
              tmr_n   = TMR_W'(gap_q);
            end else begin
              state_n = S_PULSE;
            end
          end
        end
        S_DONE: begin
          if (se_rise) begin
            state_n     = S_IDLE;
            pulse_cnt_n = '0;
          end
        end
        default: begin
          state_n     = S_IDLE;
          pulse_cnt_n = '0;
          tmr_n       = '0;
        end
      endcase
      // Enable is high in exactly the cycles the FSM sits in PULSE
      clken_n = (state_n == S_PULSE);
    end
  end

  assign o_busy = (state == S_WAIT) || (state == S_PULSE) || (state == S_GAP);
  assign o_done = (state == S_DONE);

endmodule
